nios_lab_nios2_gen2_0_cpu_ocimem_arbiter: RTL and testbench
===========================================================

Name: nios_lab_nios2_gen2_0_cpu_ocimem_arbiter

Overview:
Arbitrates one single-port on-chip debug RAM between two requesters: JTAG debug commands (non-stallable strobes decoded from jdo) and CPU Avalon debug_mem_slave accesses (stallable through waitrequest). Includes a one-entry JTAG command buffer, JTAG address auto-increment, and a JTAG read-back register (MonDReg) with a ready flag. Sits between the debug slave sysclk block and the OCI RAM, all in the clk domain.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, RAM data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jtag_ld_addr  in  1  strobe: load JTAG address from jtag_addr_in
jtag_addr_in  in  ADDR_W  JTAG start address
jtag_cmd  in  1  strobe: issue one JTAG access at the current JTAG address
jtag_cmd_wr  in  1  qualifies jtag_cmd: 1=write, 0=read
jtag_wdata  in  DATA_W  JTAG write data, sampled with jtag_cmd
MonDReg  out  DATA_W  JTAG read-back data
monitor_ready  out  1  high when MonDReg holds fresh read data
jtag_overrun  out  1  sticky: jtag_cmd arrived while the buffer was full
avs_read  in  1  Avalon read request
avs_write  in  1  Avalon write request
avs_address  in  ADDR_W  Avalon word address
avs_writedata  in  DATA_W  Avalon write data
avs_readdata  out  DATA_W  Avalon read data
avs_readdatavalid  out  1  one-cycle pulse with avs_readdata
avs_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset (sync, high): all outputs 0 except avs_waitrequest=1; JTAG address 0; buffer empty; FSM in IDLE; sticky flags cleared.
- JTAG buffer: one entry {wr, addr, data}. jtag_cmd with buffer empty loads it using the current JTAG address, then the JTAG address increments modulo 2^ADDR_W (wrap 0xFF->0x00). jtag_cmd with buffer full: command dropped, address not incremented, jtag_overrun set until reset.
- jtag_ld_addr takes effect the same cycle; if asserted together with jtag_cmd, the command uses jtag_addr_in and the address becomes jtag_addr_in+1.
- A read command clears monitor_ready when it is buffered.
- FSM states: IDLE, J_RD, AV_RD, RDATA.
- IDLE grant rule: JTAG buffer full and last_grant != JTAG, or no Avalon request -> grant JTAG; otherwise, with an Avalon request pending -> grant Avalon. last_grant updates on every grant. Back-to-back requests therefore alternate.
- JTAG write grant: one cycle; ram_we=1, ram_addr and ram_wdata from the buffer; buffer empties; stay in IDLE.
- JTAG read grant: drive ram_addr and go to J_RD. In J_RD: MonDReg<=ram_rdata, monitor_ready<=1, buffer empties, return to IDLE. Latency is 2 clks from grant to monitor_ready.
- Avalon: avs_waitrequest=0 only in the grant cycle. Write completes in that cycle (ram_we=1). Read drives ram_addr, goes to AV_RD; next cycle avs_readdata<=ram_rdata and avs_readdatavalid pulses for 1 cycle the cycle after that (RDATA, registered); back to IDLE. No new Avalon grant is given until the valid pulse has been issued.
- avs_read and avs_write together: treated as write.
- The FSM stays in IDLE for a cycle with ram_we=0 whenever nothing is pending.
- Reset mid-operation: an in-flight read is abandoned with no valid pulse and no monitor_ready; buffered JTAG command discarded.
- ram_we is never asserted outside a grant cycle. Only one requester drives the RAM per cycle.

Test Plan:
- Reset, then idle 10 clks -> avs_waitrequest=1, ram_we=0, monitor_ready=0, jtag_overrun=0.
- jtag_ld_addr with 0x10, then 3 jtag_cmd writes (data 0xA,0xB,0xC) spaced 4 clks apart -> RAM 0x10..0x12 = A,B,C; the following JTAG read at 0x13 returns the RAM content, with monitor_ready 2 clks after grant.
- Avalon reads held continuously while JTAG reads arrive every 3 clks -> grants alternate JTAG/Avalon; Avalon valid pulses are 1 clk long with correct data; no JTAG command is lost.
- JTAG address at 0xFF, 2 writes -> second write lands at 0x00.
- Two jtag_cmd on consecutive clks while Avalon is mid-read -> second command dropped, jtag_overrun=1, JTAG address advanced by 1 only.
- Reset asserted the cycle after an Avalon read grant -> no avs_readdatavalid; after release avs_waitrequest=1, then a new read completes normally.

Source files
------------

// File: rtl/nios_lab_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares one single-port RAM between buffered JTAG
// debug commands and stallable Avalon debug_mem_slave accesses.
module nios_lab_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_ld_addr,
  input  logic [ADDR_W-1:0] jtag_addr_in,
  input  logic              jtag_cmd,
  input  logic              jtag_cmd_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] J_RD  = 2'd1;
  localparam logic [1:0] AV_RD = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_jtag;
  logic [ADDR_W-1:0] jaddr;
  logic              buf_full;
  logic              buf_wr;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              grant_j;
  logic              grant_a;
  logic              av_req;
  logic              buf_accept;
  logic              buf_clear;
  logic [ADDR_W-1:0] cmd_addr;

  assign av_req     = avs_read | avs_write;
  assign cmd_addr   = jtag_ld_addr ? jtag_addr_in : jaddr;
  assign buf_accept = jtag_cmd & ~buf_full;
  assign buf_clear  = (grant_j & buf_wr) | (state == J_RD);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, grant decision and RAM/Avalon handshake drive
  always_comb begin
    state_nxt       = state;
    grant_j         = 1'b0;
    grant_a         = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_we          = 1'b0;
    avs_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (buf_full && (!last_jtag || !av_req)) begin
            grant_j  = 1'b1;
            ram_addr = buf_addr;
            if (buf_wr) begin
              ram_we    = 1'b1;
              ram_wdata = buf_data;
            end else begin
              state_nxt = J_RD;
            end
          end else if (av_req) begin
            // A simultaneous read and write is served as a write
            grant_a         = 1'b1;
            avs_waitrequest = 1'b0;
            ram_addr        = avs_address;
            if (avs_write) begin
              ram_we    = 1'b1;
              ram_wdata = avs_writedata;
            end else begin
              state_nxt = AV_RD;
            end
          end
        end
      end
      J_RD:    state_nxt = IDLE;
      AV_RD:   state_nxt = RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // JTAG address, command buffer, read-back and Avalon read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_jtag         <= 1'b0;
      jaddr             <= '0;
      buf_full          <= 1'b0;
      buf_wr            <= 1'b0;
      buf_addr          <= '0;
      buf_data          <= '0;
      jtag_overrun      <= 1'b0;
      MonDReg           <= '0;
      monitor_ready     <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (grant_j || grant_a) last_jtag <= grant_j;

      if (jtag_ld_addr) jaddr <= jtag_addr_in;
      if (buf_accept) begin
        jaddr    <= cmd_addr + ADDR_W'(1);
        buf_full <= 1'b1;
        buf_wr   <= jtag_cmd_wr;
        buf_addr <= cmd_addr;
        buf_data <= jtag_wdata;
      end else if (buf_clear) begin
        buf_full <= 1'b0;
      end

      if (jtag_cmd && buf_full) jtag_overrun <= 1'b1;

      // The buffer is full throughout J_RD, so no new read can collide here
      if (state == J_RD) begin
        MonDReg       <= ram_rdata;
        monitor_ready <= 1'b1;
      end else if (buf_accept && !jtag_cmd_wr) begin
        monitor_ready <= 1'b0;
      end

      avs_readdatavalid <= (state == AV_RD);
      if (state == AV_RD) avs_readdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_nios_lab_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Randomized scoreboard bench for the OCI debug RAM arbiter with an
// external synchronous-read RAM model and an address-level reference memory.
module tb_nios_lab_nios2_gen2_0_cpu_ocimem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;

  logic              clk;
  logic              reset;
  logic              jtag_ld_addr;
  logic [ADDR_W-1:0] jtag_addr_in;
  logic              jtag_cmd;
  logic              jtag_cmd_wr;
  logic [DATA_W-1:0] jtag_wdata;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready;
  logic              jtag_overrun;
  logic              avs_read;
  logic              avs_write;
  logic [ADDR_W-1:0] avs_address;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] av_q[$];
  logic [DATA_W-1:0] mdr_q[$];
  logic [ADDR_W-1:0] model_jaddr;
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;

  nios_lab_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .jtag_ld_addr(jtag_ld_addr), .jtag_addr_in(jtag_addr_in),
    .jtag_cmd(jtag_cmd), .jtag_cmd_wr(jtag_cmd_wr), .jtag_wdata(jtag_wdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: synchronous read, one-cycle latency
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected data whenever the DUT presents read data
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      chk("avs_valid_width", 32'(prev_valid), 32'd0);
      if (av_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL avs_unexpected_valid actual=0x%0h required=none", avs_readdata);
      end else begin
        chk("avs_readdata", avs_readdata, av_q.pop_front());
      end
    end
    if (monitor_ready === 1'b1 && !prev_ready) begin
      if (mdr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mondreg_unexpected actual=0x%0h required=none", MonDReg);
      end else begin
        chk("MonDReg", MonDReg, mdr_q.pop_front());
      end
    end
    prev_valid = (avs_readdatavalid === 1'b1);
    prev_ready = (monitor_ready === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_load(input logic [ADDR_W-1:0] addr);
    jtag_ld_addr = 1'b1;
    jtag_addr_in = addr;
    model_jaddr  = addr;
    tick();
    jtag_ld_addr = 1'b0;
  endtask

  // One jtag_cmd strobe; the model applies it only when it is expected to be accepted
  task automatic jtag_issue(input logic wr, input logic [DATA_W-1:0] data,
                            input logic ld, input logic [ADDR_W-1:0] addr, input logic accept);
    logic [ADDR_W-1:0] a;
    jtag_cmd     = 1'b1;
    jtag_cmd_wr  = wr;
    jtag_wdata   = data;
    jtag_ld_addr = ld;
    jtag_addr_in = addr;
    a = ld ? addr : model_jaddr;
    if (accept) begin
      if (wr) ref_mem[a] = data;
      else    mdr_q.push_back(ref_mem[a]);
      model_jaddr = a + 8'd1;
    end else if (ld) begin
      model_jaddr = addr;
    end
    tick();
    jtag_cmd     = 1'b0;
    jtag_ld_addr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (monitor_ready !== 1'b1 && n < 60);
    if (monitor_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL monitor_ready_timeout actual=0 required=1");
    end
    tick();
  endtask

  task automatic wait_accept(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(negedge clk);
      n++;
      if (avs_waitrequest === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL avs_accept_timeout actual=1 required=0");
    end
  endtask

  task automatic av_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
    bit ok;
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = addr;
    avs_writedata = data;
    wait_accept(ok);
    if (ok) begin
      if (wr) ref_mem[addr] = data;
      else    av_q.push_back(ref_mem[addr]);
    end
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  // Continuous Avalon reads: avs_read stays high, the address changes after each accept
  task automatic av_burst(input int n);
    bit ok;
    avs_read = 1'b1;
    for (int i = 0; i < n; i++) begin
      avs_address = ADDR_W'($urandom);
      wait_accept(ok);
      if (ok) av_q.push_back(ref_mem[avs_address]);
      tick();
    end
    avs_read = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = {8'(i), 24'($urandom)};
      ref_mem[i] = ram[i];
    end
    reset = 1'b1;
    jtag_ld_addr = 1'b0; jtag_addr_in = '0; jtag_cmd = 1'b0; jtag_cmd_wr = 1'b0; jtag_wdata = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    model_jaddr = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_monitor_ready", 32'(monitor_ready), 32'd0);
    chk("reset_overrun", 32'(jtag_overrun), 32'd0);
    chk("reset_valid", 32'(avs_readdatavalid), 32'd0);
    tick();

    // JTAG writes from a loaded address, then a read with latency check
    jtag_load(8'h10);
    jtag_issue(1'b1, 32'hA, 1'b0, '0, 1'b1); repeat (3) tick();
    jtag_issue(1'b1, 32'hB, 1'b0, '0, 1'b1); repeat (3) tick();
    jtag_issue(1'b1, 32'hC, 1'b0, '0, 1'b1); repeat (3) tick();
    jtag_issue(1'b0, '0, 1'b0, '0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (monitor_ready !== 1'b1 && n < 20);
    chk("mready_latency", 32'(n), 32'd3);
    tick();
    for (int a = 16; a < 19; a++) av_access(1'b1, 1'b0, 8'(a), '0);

    // Continuous Avalon reads contending with periodic JTAG reads
    fork
      av_burst(8);
      begin
        for (int k = 0; k < 4; k++) begin
          jtag_issue(1'b0, '0, 1'b0, '0, 1'b1);
          wait_ready();
          repeat (2) tick();
        end
      end
    join
    repeat (4) tick();
    chk("no_overrun_contention", 32'(jtag_overrun), 32'd0);

    // Address wrap, with load and command in the same cycle
    jtag_issue(1'b1, 32'hAAAA0001, 1'b1, 8'hFF, 1'b1); repeat (3) tick();
    jtag_issue(1'b1, 32'hBBBB0002, 1'b0, '0, 1'b1);    repeat (3) tick();
    av_access(1'b1, 1'b0, 8'hFF, '0);
    av_access(1'b1, 1'b0, 8'h00, '0);
    jtag_issue(1'b0, '0, 1'b0, '0, 1'b1);
    wait_ready();

    // Read and write together behave as a write
    av_access(1'b1, 1'b1, 8'h55, 32'hC0DE_0055);
    av_access(1'b1, 1'b0, 8'h55, '0);
    repeat (4) tick();

    // Two back-to-back JTAG commands while an Avalon read is in flight
    avs_read = 1'b1;
    avs_address = 8'h40;
    wait_accept(ok);
    if (ok) av_q.push_back(ref_mem[8'h40]);
    tick();
    avs_read = 1'b0;
    jtag_cmd = 1'b1; jtag_cmd_wr = 1'b0; jtag_ld_addr = 1'b1; jtag_addr_in = 8'h20;
    mdr_q.push_back(ref_mem[8'h20]);
    model_jaddr = 8'h21;
    tick();
    jtag_ld_addr = 1'b0;
    tick();
    jtag_cmd = 1'b0;
    wait_ready();
    chk("overrun_set", 32'(jtag_overrun), 32'd1);
    jtag_issue(1'b0, '0, 1'b0, '0, 1'b1);
    wait_ready();

    // Reset the cycle after an Avalon read grant
    avs_read = 1'b1;
    avs_address = 8'h33;
    wait_accept(ok);
    tick();
    reset = 1'b1;
    avs_read = 1'b0;
    model_jaddr = '0;
    tick();
    @(negedge clk);
    chk("midreset_waitrequest", 32'(avs_waitrequest), 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("post_reset_ram_we", 32'(ram_we), 32'd0);
    chk("post_reset_overrun", 32'(jtag_overrun), 32'd0);
    chk("post_reset_mready", 32'(monitor_ready), 32'd0);
    tick();
    av_access(1'b1, 1'b0, 8'h33, '0);
    jtag_issue(1'b0, '0, 1'b0, '0, 1'b1);
    wait_ready();

    repeat (6) tick();
    chk("av_queue_drained", 32'(av_q.size()), 32'd0);
    chk("mdr_queue_drained", 32'(mdr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
